// File: rtl/mul_product_combine.sv
// Reassembles signed DSP partial products into SEW-wide element results for the vALU multiply path.
// SEW=64 arrives as two beats that accumulate in a 128-bit register before the result is emitted.
module mul_product_combine #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned PP_WIDTH      = 36,
  parameter bit          ENABLE_64_BIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            in_sew,
  input  logic                  in_high,
  input  logic [PP_WIDTH-1:0]   pp0,
  input  logic [PP_WIDTH-1:0]   pp1,
  input  logic [PP_WIDTH-1:0]   pp2,
  input  logic [PP_WIDTH-1:0]   pp3,
  input  logic [PP_WIDTH-1:0]   pp4,
  input  logic [PP_WIDTH-1:0]   pp5,
  input  logic [PP_WIDTH-1:0]   pp6,
  input  logic [PP_WIDTH-1:0]   pp7,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned AccW = 128;
  localparam int unsigned ResW = (DATA_WIDTH > 64) ? DATA_WIDTH : 64;

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e            state_q;
  logic [AccW-1:0]   acc_q;
  logic              high_q;

  logic [PP_WIDTH-1:0] pp_raw [8];
  logic [AccW-1:0]     pp_ext [8];
  logic [AccW-1:0]     beat_sum;
  logic [AccW-1:0]     acc_sum;
  logic [63:0]         lane_sum;
  logic [ResW-1:0]     single_res;
  logic [ResW-1:0]     wide_res;
  logic                beat64;

  assign pp_raw[0] = pp0;
  assign pp_raw[1] = pp1;
  assign pp_raw[2] = pp2;
  assign pp_raw[3] = pp3;
  assign pp_raw[4] = pp4;
  assign pp_raw[5] = pp5;
  assign pp_raw[6] = pp6;
  assign pp_raw[7] = pp7;

  assign beat64 = (in_sew == 2'b11);

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      pp_ext[k] = {{(AccW-PP_WIDTH){pp_raw[k][PP_WIDTH-1]}}, pp_raw[k]};
    end
  end

  // Single-beat element results for SEW=8/16/32.
  always_comb begin
    single_res = '0;
    lane_sum   = '0;
    case (in_sew)
      2'b00: begin
        for (int k = 0; k < 8; k++) begin
          single_res[8*k +: 8] = in_high ? pp_ext[k][15:8] : pp_ext[k][7:0];
        end
      end
      2'b01: begin
        for (int k = 0; k < 4; k++) begin
          single_res[16*k +: 16] = in_high ? pp_ext[k][31:16] : pp_ext[k][15:0];
        end
      end
      2'b10: begin
        for (int l = 0; l < 2; l++) begin
          lane_sum = 64'(pp_ext[4*l]
                         + ((pp_ext[4*l+1] + pp_ext[4*l+2]) << 16)
                         + (pp_ext[4*l+3] << 32));
          single_res[32*l +: 32] = in_high ? lane_sum[63:32] : lane_sum[31:0];
        end
      end
      default: single_res = '0;
    endcase
  end

  // Beat 1 has the same chunk layout as beat 0 with b-chunk index raised by two (weight 2^32).
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) begin
        beat_sum = beat_sum + (pp_ext[2*i+j] << (16 * (i + j)));
      end
    end
  end

  assign acc_sum  = acc_q + (beat_sum << 32);
  assign wide_res = ResW'(high_q ? acc_sum[127:64] : acc_sum[63:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      high_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (beat64) begin
              if (ENABLE_64_BIT) begin
                acc_q   <= beat_sum;
                high_q  <= in_high;
                busy    <= 1'b1;
                state_q <= StAcc;
              end else begin
                err <= 1'b1;
              end
            end else begin
              out_valid  <= 1'b1;
              out_result <= single_res[DATA_WIDTH-1:0];
            end
          end
        end
        StAcc: begin
          if (in_valid) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            acc_q     <= '0;
            out_valid <= 1'b1;
            if (beat64) begin
              out_result <= wide_res[DATA_WIDTH-1:0];
            end else begin
              // Held beat 0 is dropped; the interrupting beat still produces its result.
              err        <= 1'b1;
              out_result <= single_res[DATA_WIDTH-1:0];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mul_product_combine.md
Name: mul_product_combine

Overview:
- Back end of the vALU multiply path: accepts the signed partial products produced by the four dual-product DSP multiplier units (m0..m3, products p0 = a0*b0, p1 = a1*b1) and reassembles them into SEW-wide element results.
- Selects the low (vmul) or high (vmulh*) half of each element's full product.
- SEW=64 needs 16 partial products, so it arrives as two beats that accumulate in a 128-bit register.
- Output is registered; a beat-tracking FSM handles the two-beat case.

Parameters:
- DATA_WIDTH, 64, result vector width (elements packed LSB-first).
- PP_WIDTH, 36, width of each signed partial product (18x18).
- ENABLE_64_BIT, 1, when 0 SEW=64 beats are rejected (err pulse, no output).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  partial-product beat valid
- in_sew  input  2  00=8, 01=16, 10=32, 11=64 bit elements
- in_high  input  1  1 = return upper half of each full product
- pp0..pp7  input  PP_WIDTH each  signed partial products (m0_p0,m0_p1,m1_p0,...,m3_p1)
- out_valid  output  1  result valid, one-cycle pulse
- out_result  output  DATA_WIDTH  packed element results
- busy  output  1  high while holding SEW=64 beat 0
- err  output  1  one-cycle protocol-error pulse

Behaviour:
- Reset: out_valid=0, out_result=0, busy=0, err=0, FSM=IDLE, accumulator=0. Reset mid-operation discards any held beat 0.
- Signedness is encoded upstream in operand-chunk extension; every pp is an exact signed term. This block does no sign handling beyond sign-extending pp to accumulator width.
- Element k occupies out_result[SEW*k +: SEW].
- SEW=8:
  - Lane k uses pp_k; the 18-bit product is sign-extended.
  - Low half = bits [7:0]; high half = bits [15:8].
- SEW=16:
  - Lane k (0..3) uses pp_k; pp4..pp7 are ignored.
  - Low half = [15:0]; high half = [31:16].
- SEW=32, lane L in {0,1}:
  - pp[4L]=lo*lo, pp[4L+1]=hi_a*lo_b, pp[4L+2]=lo_a*hi_b, pp[4L+3]=hi*hi.
  - sum = pp[4L] + ((pp[4L+1]+pp[4L+2])<<16) + (pp[4L+3]<<32), computed at 64 bits.
  - Low half = sum[31:0]; high half = sum[63:32].
- SEW=64: chunk product a_i*b_j has weight 2^(16(i+j)).
  - Beat 0 carries j in {0,1} at pp[2i+j].
  - Beat 1 carries j in {2,3} at pp[2i+j-2].
  - Each beat's weighted sum is added into a 128-bit accumulator.
  - Result is acc[63:0] (low) or acc[127:64] (high).
- Latency: 1 cycle. out_valid asserts the cycle after the completing beat (any single-beat SEW, or SEW=64 beat 1).
- FSM:
  - IDLE: a valid SEW=64 beat → ACC; acc := beat-0 sum; in_high latched; busy=1.
  - IDLE: a valid non-64 beat → output next cycle, stay IDLE.
  - ACC: in_valid=0 holds state (gaps between beats allowed).
  - ACC: a valid SEW=64 beat → complete (acc + beat-1 sum), out_valid next cycle, → IDLE. in_high is taken from beat 0.
  - ACC: a valid non-64 beat → err pulse next cycle; held beat 0 is dropped; the new beat is processed normally; → IDLE.
- ENABLE_64_BIT=0: a valid SEW=64 beat → err pulse, no out_valid, stays IDLE.
- No backpressure: downstream must accept every out_valid pulse. out_result holds its last value while out_valid=0.

Test Plan:
1. SEW=16, pp0=-15 (-3*5), pp1..3=0, in_high=0 → out_valid after 1 cycle, out_result[15:0]=0xFFF1. Same with in_high=1 → 0xFFFF.
2. SEW=8, pp3=254 (0x7F*0x02) → out_result[31:24]=0xFE (low), 0x00 (high); other lanes 0.
3. SEW=32 lane 0, a=0x00010002, b=0x00030004: pp0=8, pp1=4, pp2=6, pp3=3 → low=0x000A0008, high=0x00000003.
4. SEW=64, a=b=0xFFFF_FFFF_FFFF_FFFF unsigned (every chunk product 0xFFFE0001), two beats with a 2-cycle gap → busy high during gap; single out_valid one cycle after beat 1; low=0x0000000000000001, high=0xFFFFFFFFFFFFFFFE.
5. SEW=64 beat 0, then a SEW=16 beat with pp0=7 → err pulses once; out_result[15:0]=7 with out_valid; no SEW=64 result ever emitted.
6. SEW=64 beat 0, rst for one cycle, then a SEW=64 beat → treated as beat 0 (busy=1, no out_valid); next beat completes normally.
